seg_scan_display: RTL
=====================

Name: seg_scan_display

Overview:
- Parametrised multiplexed seven-segment driver; next generation of the fixed 8-digit MBR/MR scanner.
- Scans NUM_DIGITS common-anode digits with a programmable dwell time and an anti-ghosting blank window.
- Uses a double-buffered display value committed only at frame boundaries, so the display never tears.
- Per-digit decimal point, per-digit forced blanking and leading-zero suppression.
- Sits between the CPU datapath and the board anode/segment pins.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (2..16)
- SCAN_CYCLES, 100000, clk cycles each digit is selected (>=2)
- BLANK_CYCLES, 0, cycles at the start of each slot with all anodes off (< SCAN_CYCLES)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- data_in  in  4*NUM_DIGITS  hex nibbles; digit k = data_in[4k+3:4k]
- load  in  1  capture data_in into the pending buffer
- dp_in  in  NUM_DIGITS  decimal point on for digit k when 1
- blank_in  in  NUM_DIGITS  force digit k dark when 1
- lz_suppress  in  1  enable leading-zero suppression
- digit_sel  out  NUM_DIGITS  anode enables, active-low, one-cold
- seg_out  out  8  segments {a,b,c,d,e,f,g,dp}, bit7=a, bit0=dp, active-low
- frame_tick  out  1  one-cycle pulse when the index wraps NUM_DIGITS-1 -> 0

Behaviour:
- Reset (rst_n=0 at posedge), all synchronous:
  - cnt=0, idx=0
  - pending=0, pending_valid=0, disp=0
  - digit_sel = all ones, seg_out = 8'hFF, frame_tick=0
- Timer:
  - cnt counts 0..SCAN_CYCLES-1 and wraps.
  - On the wrap edge, idx advances modulo NUM_DIGITS.
  - frame_tick=1 for exactly the cycle following the edge where idx goes NUM_DIGITS-1 -> 0.
- Buffering:
  - load=1 writes data_in to pending and sets pending_valid.
  - On the frame-boundary edge with pending_valid=1: disp <= pending and pending_valid is cleared.
  - load on the same edge as the boundary: disp <= data_in directly (bypass) and pending_valid=0.
  - Multiple loads within one frame: the last one wins.
- Decode: hex glyph table, active-low. Examples: 0=8'h03, 1=8'h9F, 8=8'h01, F=8'h71; dp clears bit0.
- Digit k is dark (seg_out=8'hFF, dp included) when either:
  - blank_in[k]=1, or
  - lz_suppress=1, k != 0, and disp nibbles k..NUM_DIGITS-1 are all zero.
- Digit 0 is never suppressed by leading-zero logic; a value of 0 shows a single "0".
- Output timing:
  - digit_sel and seg_out are registered and lag (idx, cnt) by one clock.
  - digit_sel[idx]=0 only when cnt >= BLANK_CYCLES; otherwise all anodes are off.
  - seg_out always carries the glyph for idx.
- dp_in, blank_in and lz_suppress are sampled live, not buffered.
- Reset mid-frame: everything returns to reset values on that edge; pending data is lost.
- Widths: idx is clog2(NUM_DIGITS) bits; cnt is clog2(SCAN_CYCLES) bits.

Decomposition:
- Package seg_pkg:
  - hex-to-segment function or 16-entry constant table
  - SEG_BLANK=8'hFF
  - segment bit-position constants
- One sub-module, seg_scan_timer: owns cnt, idx and the frame_tick/slot-wrap strobes, parametrised by NUM_DIGITS and SCAN_CYCLES.
- Buffering, suppression and output registers stay in the top.

Test Plan (NUM_DIGITS=4, SCAN_CYCLES=4, BLANK_CYCLES=1 unless noted):
- Reset release:
  - Stimulus: rst_n low 3 cycles, then high; data_in=16'h1234, load pulsed once.
  - Required: digit_sel=4'hF and seg_out=8'hFF during reset.
  - Required: the first frame shows 0 on every digit, the next frame shows 4,3,2,1 on digits 0..3 (seg 8'h99, 8'h0D, 8'h25, 8'h9F).
  - Required: frame_tick pulses every 16 cycles.
- Anti-ghost window:
  - Required: in each 4-cycle slot, digit_sel=4'hF for 1 cycle, then the one-cold pattern (e.g. 4'hE for digit 0) for 3 cycles.
- Tear-free update:
  - Stimulus: load 16'hAAAA mid-frame, then 16'h5555 two cycles later, same frame.
  - Required: the current frame is unchanged; the next frame shows only 5 (8'h49) on all digits.
- Boundary bypass:
  - Stimulus: load 16'h00F0 on the exact wrap edge.
  - Required: the frame starting at that edge shows F on digit 1 (8'h71).
- Leading-zero suppression:
  - Stimulus: disp=16'h0070, lz_suppress=1.
  - Required: digits 3,2 show 8'hFF, digit 1 shows 8'h1F, digit 0 shows 8'h03.
  - Stimulus: disp=0.
  - Required: only digit 0 shows 8'h03.
- DP/blank:
  - Stimulus: dp_in=4'b0010, blank_in=4'b0001, disp=16'h8888.
  - Required: digit 1 shows 8'h00, digit 0 shows 8'hFF, others 8'h01.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and the hex glyph decoder for the seven-segment scanner.
// Segment vectors are {a,b,c,d,e,f,g,dp}, active-low.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int SEG_A_BIT  = 7;
  localparam int SEG_G_BIT  = 1;
  localparam int SEG_DP_BIT = 0;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
    logic [7:0] seg;
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = 8'h03;
      4'h1: seg = 8'h9F;
      4'h2: seg = 8'h25;
      4'h3: seg = 8'h0D;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h49;
      4'h6: seg = 8'h41;
      4'h7: seg = 8'h1F;
      4'h8: seg = 8'h01;
      4'h9: seg = 8'h09;
      4'hA: seg = 8'h11;
      4'hB: seg = 8'hC1;
      4'hC: seg = 8'h63;
      4'hD: seg = 8'h85;
      4'hE: seg = 8'h61;
      4'hF: seg = 8'h71;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Dwell timer and digit index for the scanner; flags the slot and frame wrap.
// frame_wrap_o is combinational (true on the edge that wraps the frame).
module seg_scan_timer #(
  parameter int NUM_DIGITS  = 8,
  parameter int SCAN_CYCLES = 100000,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] cnt_o,
  output logic [IW-1:0] idx_o,
  output logic          frame_wrap_o,
  output logic          frame_tick_o
);

  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_CYCLES - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          tick_q;
  logic          slot_wrap;
  logic          frame_wrap;

  always_comb begin
    slot_wrap  = (cnt_q == CNT_MAX);
    frame_wrap = slot_wrap && (idx_q == IDX_MAX);
    cnt_d      = slot_wrap ? '0 : cnt_q + 1'b1;
    idx_d      = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      tick_q <= frame_wrap;
    end
  end

  assign cnt_o        = cnt_q;
  assign idx_o        = idx_q;
  assign frame_wrap_o = frame_wrap;
  assign frame_tick_o = tick_q;

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed common-anode seven-segment driver with a double-buffered value
// that is committed only at frame boundaries, plus dp, blanking and lz suppression.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_suppress,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [7:0]              seg_out,
  output logic                    frame_tick
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          frame_wrap;

  seg_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SCAN_CYCLES (SCAN_CYCLES)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .cnt_o        (cnt),
    .idx_o        (idx),
    .frame_wrap_o (frame_wrap),
    .frame_tick_o (frame_tick)
  );

  logic [DW-1:0]         pending_q, pending_d;
  logic                  pending_valid_q, pending_valid_d;
  logic [DW-1:0]         disp_q, disp_d;
  logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic [7:0]            seg_q, seg_d;
  logic                  in_window;
  logic [NUM_DIGITS-1:0][7:0] glyph;

  // A load coinciding with the frame wrap bypasses the pending buffer.
  always_comb begin
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    disp_d          = disp_q;
    if (load) begin
      pending_d = data_in;
    end
    if (frame_wrap) begin
      pending_valid_d = 1'b0;
      if (load) begin
        disp_d = data_in;
      end else if (pending_valid_q) begin
        disp_d = pending_q;
      end
    end else if (load) begin
      pending_valid_d = 1'b1;
    end
  end

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_window = 1'b1;
    end else begin : g_blank
      assign in_window = (cnt >= CW'(BLANK_CYCLES));
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic       dark;
      logic [7:0] lit;
      if (gi == 0) begin : g_lsd
        assign dark = blank_in[0];
      end else begin : g_upper
        assign dark = blank_in[gi] |
                      (lz_suppress & (disp_q[DW-1:4*gi] == '0));
      end
      always_comb begin
        lit = hex_to_seg(disp_q[4*gi +: 4]);
        if (dp_in[gi]) begin
          lit[SEG_DP_BIT] = 1'b0;
        end
      end
      assign glyph[gi] = dark ? SEG_BLANK : lit;
    end
  endgenerate

  always_comb begin
    seg_d       = glyph[idx];
    digit_sel_d = '1;
    if (in_window) begin
      digit_sel_d = ~(NUM_DIGITS'(1) << idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      disp_q          <= '0;
      digit_sel_q     <= '1;
      seg_q           <= SEG_BLANK;
    end else begin
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      disp_q          <= disp_d;
      digit_sel_q     <= digit_sel_d;
      seg_q           <= seg_d;
    end
  end

  assign digit_sel = digit_sel_q;
  assign seg_out   = seg_q;

endmodule
